// File: rtl/aes_pkg.sv
// Shared AES key-schedule types: word/block typedefs, scheduler states and the rcon table.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

    // Entry 0 is unused padding so the table is indexed directly by round number.
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        return (r <= 4'd10) ? RCON[r] : 8'h00;
    endfunction

endpackage

// File: rtl/sbox.sv
// AES S-box computed arithmetically (GF(2^8) inverse plus affine map); sel=1 forward, sel=0 inverse.
module sbox (
    input  logic       sel,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 == x^-1, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_aff(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_aff(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] pre;
    logic [7:0] inv;

    always_comb begin
        pre  = sel ? din : inv_aff(din);
        inv  = gf_inv(pre);
        dout = sel ? fwd_aff(inv) : inv;
    end

endmodule

// File: rtl/sub_word.sv
// SubWord: four forward S-boxes applied bytewise to a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  word_t din,
    output word_t dout
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        sbox u_sbox (
            .sel  (1'b1),
            .din  (din[8*i +: 8]),
            .dout (dout[8*i +: 8])
        );
    end

endmodule

// File: rtl/inv_key_sched.sv
// AES-128 inverse key scheduler: expands a key forward to round 10, then streams round keys 10..0.
// Build option: define AES_RK_ZEROIZE_EN to clear the key register after the round-0 transfer.
module inv_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         busy
);

    state_t     state, state_nxt;
    block_t     rk;
    logic [3:0] rnd;
    logic [3:0] rnd_inc;
    logic       xfer;

    word_t a, b, c, d;
    word_t sw_in, sw_out;
    word_t a_f, b_f, c_f, d_f;
    word_t a_b, b_b, c_b, d_b;

    assign {a, b, c, d} = rk;
    assign rnd_inc      = rnd + 4'd1;
    assign xfer         = rk_valid && rk_ready;

    // Backward step needs SubWord(RotWord(d^c)); forward needs SubWord(RotWord(d)).
    assign d_b   = d ^ c;
    assign c_b   = c ^ b;
    assign b_b   = b ^ a;
    assign sw_in = (state == STREAM) ? {d_b[23:0], d_b[31:24]} : {d[23:0], d[31:24]};

    sub_word u_sub_word (
        .din  (sw_in),
        .dout (sw_out)
    );

    assign a_b = a ^ sw_out ^ {rcon(rnd), 24'h0};
    assign a_f = a ^ sw_out ^ {rcon(rnd_inc), 24'h0};
    assign b_f = b ^ a_f;
    assign c_f = c ^ b_f;
    assign d_f = d ^ c_f;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // EXPAND runs rounds 1..10 then spends one more cycle at rnd==10 before streaming.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (key_valid)          state_nxt = EXPAND;
            EXPAND:  if (rnd == 4'd10)       state_nxt = STREAM;
            STREAM:  if (xfer && rnd == 4'd0) state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rk  <= '0;
            rnd <= 4'd0;
        end else begin
            case (state)
                IDLE: if (key_valid) begin
                    rk  <= key_in;
                    rnd <= 4'd0;
                end
                EXPAND: if (rnd != 4'd10) begin
                    rk  <= {a_f, b_f, c_f, d_f};
                    rnd <= rnd_inc;
                end
                STREAM: if (xfer) begin
                    if (rnd == 4'd0) begin
`ifdef AES_RK_ZEROIZE_EN
                        rk <= '0;
`endif
                    end else begin
                        rk  <= {a_b, b_b, c_b, d_b};
                        rnd <= rnd - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign key_ready = (state == IDLE);
    assign rk_valid  = (state == STREAM);
    assign busy      = (state != IDLE);
    assign rk_out    = rk;
    assign rk_round  = rnd;

endmodule

// File: tb/tb_inv_key_sched.sv
// Directed bench for inv_key_sched using FIPS-197 round keys; honours AES_RK_ZEROIZE_EN.
module tb_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [127:0] ka [0:10];
    localparam logic [127:0] KEY_B   = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] KEY2    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    always #5 clk = ~clk;

    inv_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_in    (key_in),
        .key_ready (key_ready),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_key_ready"}, 128'(key_ready), 128'd1);
        chk({tag, "_rk_valid"},  128'(rk_valid),  128'd0);
        chk({tag, "_busy"},      128'(busy),      128'd0);
    endtask

    task automatic offer(input logic [127:0] k);
        key_valid = 1'b1;
        key_in    = k;
        step();
        key_valid = 1'b0;
        key_in    = KEY_B;
        chk("accept_busy",      128'(busy),      128'd1);
        chk("accept_key_ready", 128'(key_ready), 128'd0);
    endtask

    // Edges T+1..T+10 leave rk_valid low; edge T+11 raises it.
    task automatic expand_wait(input bit inject);
        for (int i = 1; i <= 10; i++) begin
            if (inject && i == 4) key_valid = 1'b1;
            step();
            key_valid = 1'b0;
            if (inject && i == 4) chk("expand_key_ready", 128'(key_ready), 128'd0);
        end
        chk("latency_low", 128'(rk_valid), 128'd0);
        step();
        chk("latency_high", 128'(rk_valid), 128'd1);
    endtask

    task automatic stream(input logic [127:0] k10, input logic [127:0] k0,
                          input bit full, input bit stall);
        logic [127:0] exp;
        rk_ready = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            chk("rk_round", 128'(rk_round), 128'(r));
            chk("rk_valid", 128'(rk_valid), 128'd1);
            if (full)         exp = ka[r];
            else if (r == 10) exp = k10;
            else              exp = k0;
            if (full || r == 10 || r == 0) chk("rk_out", rk_out, exp);
            if (stall && r == 7) begin
                rk_ready  = 1'b0;
                key_valid = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    step();
                    chk("stall_round", 128'(rk_round), 128'd7);
                    chk("stall_out",   rk_out,         exp);
                    chk("stall_key_ready", 128'(key_ready), 128'd0);
                end
                key_valid = 1'b0;
                rk_ready  = 1'b1;
            end
            step();
        end
        chk_idle("done");
`ifdef AES_RK_ZEROIZE_EN
        chk("idle_rk_out", rk_out, 128'h0);
`else
        chk("idle_rk_out", rk_out, k0);
`endif
    endtask

    initial begin
        ka[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ka[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        ka[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        ka[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        ka[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        ka[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        ka[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        ka[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        ka[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        ka[9]  = 128'hac7766f319fadc2128d12941575c006e;
        ka[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst       = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset_round",  128'(rk_round), 128'd0);
        chk("reset_rk_out", rk_out,         128'h0);

        // FIPS-197 key, stall at round 7, stray keys offered while busy.
        offer(ka[0]);
        expand_wait(1'b1);
        stream(ka[10], ka[0], 1'b1, 1'b1);

        // Abort mid-expansion, then a fresh key must be unaffected.
        offer(ka[0]);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("abort");
        chk("abort_round",  128'(rk_round), 128'd0);
        chk("abort_rk_out", rk_out,         128'h0);
        offer(KEY2);
        expand_wait(1'b0);
        stream(KEY2_10, KEY2, 1'b0, 1'b0);

        // Second key offered in the first idle cycle after the round-0 transfer.
        offer(ka[0]);
        expand_wait(1'b0);
        stream(ka[10], ka[0], 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inv_key_sched.md
INV_KEY_SCHED -- requirements
Module: inv_key_sched

Interface
REQ-001 The block SHALL have these ports:
- clk, input, 1: sole clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- key_valid, input, 1: cipher key offered.
- key_in, input, 128: AES-128 cipher key, byte 0 in [127:120].
- key_ready, output, 1: block can accept a key.
- rk_valid, output, 1: round key presented.
- rk_ready, input, 1: consumer accepts the round key.
- rk_out, output, 128: round key, same byte order as key_in.
- rk_round, output, 4: round index of rk_out (10 down to 0).
- busy, output, 1: block is not in IDLE.

Function
REQ-002 The block SHALL implement states IDLE, EXPAND and STREAM, and no others.
REQ-003 Transitions SHALL be as follows:
- IDLE to EXPAND on key_valid && key_ready.
- EXPAND to STREAM after 10 expansion cycles.
- STREAM to IDLE on the rk_valid && rk_ready transfer with rk_round==0.
REQ-004 key_ready SHALL be 1 only in IDLE; key_valid SHALL be ignored outside IDLE.
REQ-005 In EXPAND, the block SHALL compute one forward round key per cycle using FIPS-197 expansion with rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
REQ-006 Expansion latency: for a key accepted at edge T, rk_valid SHALL rise after edge T+11, with rk_round=10 and rk_out equal to the round-10 key.
REQ-007 In STREAM, each rk_valid && rk_ready transfer SHALL replace the round-r key with the round-(r-1) key on the next edge and decrement rk_round, with no bubble cycles.
REQ-008 The backward step SHALL be computed from K_r = (a,b,c,d):
- d' = d^c
- c' = c^b
- b' = b^a
- a' = a ^ SubWord(RotWord(d')) ^ {rcon[r],24'h0}
REQ-009 While rk_valid=1 and rk_ready=0, rk_out and rk_round SHALL hold stable.
REQ-010 rk_valid SHALL be 1 only in STREAM; rk_out SHALL be don't-care when rk_valid=0 unless REQ-016 applies.
REQ-011 After the round-0 transfer, the block SHALL deassert rk_valid and assert key_ready on the next cycle.
REQ-012 busy SHALL be 1 in EXPAND and STREAM.
REQ-013 The round counter SHALL be 4 bits and SHALL never leave the range 0..10.

Reset
REQ-014 When rst=1 at an edge, the block SHALL:
- enter IDLE;
- set key_ready=1, rk_valid=0, busy=0, rk_round=0, rk_out=128'h0.
REQ-015 rst asserted mid-EXPAND or mid-STREAM SHALL abort the operation; the discarded key SHALL NOT affect later operations.

Configuration
REQ-016 With AES_RK_ZEROIZE_EN defined, the block SHALL clear the key/round-key register to 128'h0 on the cycle after the round-0 transfer. In IDLE, rk_out SHALL then read 128'h0.
REQ-017 Without AES_RK_ZEROIZE_EN, the register SHALL retain the round-0 key in IDLE. All other behaviour SHALL be identical in both configurations.

Structure
REQ-018 The shared package aes_pkg SHALL hold:
- the rcon table;
- the 32-bit word typedef;
- the 128-bit block typedef;
- the state enum.
REQ-019 SubWord SHALL be a sub-module sub_word containing four existing sbox instances with sel tied to forward.
REQ-020 A single sub_word instance SHALL be shared between EXPAND and STREAM; its input is muxed by state.

Verification
REQ-021 Send key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1. Required response:
- After 11 cycles: rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Next cycle: ac7766f319fadc2128d12941575c006e.
- Final transfer: rk_round=0, rk_out=2b7e151628aed2a6abf7158809cf4f3c.
REQ-022 Hold rk_ready=0 for 5 cycles at rk_round=7 -> rk_out and rk_round stay constant; the sequence then resumes with no skipped rounds.
REQ-023 Pulse key_valid with a different key during EXPAND and STREAM -> ignored; key_ready=0; the output sequence is unchanged.
REQ-024 Assert rst during EXPAND (cycle 5), then send key 000102030405060708090a0b0c0d0e0f -> round-10 key 13111d7fe3944a17f307a78b4d2b30c5 and correct streaming.
REQ-025 Issue two keys back-to-back, with the second offered the cycle after the round-0 transfer -> accepted that cycle; full correct sequence for both.
REQ-026 With AES_RK_ZEROIZE_EN defined, rk_out=128'h0 in IDLE after completion; without it, rk_out holds the round-0 key.
